// File: rtl/wt_seg_sched.sv
// Weight-segment scheduler: walks a kernel region of the weight buffer and emits
// one tagged, byte-masked segment per word through a 2-entry fall-through queue.
module wt_seg_sched #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int KCNT_W = 16,
  parameter int WORD_W = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kernel_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [KCNT_W-1:0] kernel_num,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              wt_valid,
  input  logic              wt_ready,
  output logic [WORD_W-1:0] wt_data,
  output logic [2:0]        wt_mode,
  output logic              wt_last_seg,
  output logic              wt_last_kernel
);

  localparam int BYTE_W = WORD_W / 9;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  typedef enum logic [2:0] {M_A = 3'd0, M_B = 3'd1, M_C = 3'd2, M_D = 3'd3, M_E = 3'd4} wt_mode_t;

  typedef struct packed {
    logic [2:0] mode;
    logic       last_seg;
    logic       last_kernel;
  } tag_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_mode5;
  logic [KCNT_W-1:0]   r_knum;
  logic [KCNT_W-1:0]   r_kcnt;
  logic [1:0]          r_seg;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_if_valid;
  tag_t                r_if_tag;
  logic [WORD_W-1:0]   r_q_data [2];
  tag_t                r_q_tag  [2];
  logic                r_q_wr;
  logic                r_q_rd;
  logic [1:0]          r_q_cnt;

  tag_t                w_issue_tag;
  logic [3:0]          w_keep;
  logic [WORD_W-1:0]   w_in_data;
  logic                w_bypass;
  logic                w_pop;
  logic                w_push;
  logic                w_qpop;
  logic [2:0]          w_occ;
  logic [2:0]          w_need;
  logic [WORD_W-1:0]   w_head_data;
  tag_t                w_head_tag;

  // Tag of the segment whose read would be issued this cycle.
  always_comb begin
    w_issue_tag.mode        = r_mode5 ? {1'b0, r_seg} : M_E;
    w_issue_tag.last_seg    = !r_mode5 || (r_seg == 2'd3);
    w_issue_tag.last_kernel = w_issue_tag.last_seg && (r_kcnt == r_knum - 1'b1);
  end

  // Mask the returning word according to the tag it was issued with.
  always_comb begin
    w_keep = 4'd9;
    case (r_if_tag.mode)
      M_B, M_C: w_keep = 4'd6;
      M_D:      w_keep = 4'd4;
      default:  w_keep = 4'd9;
    endcase
    w_in_data = '0;
    for (int b = 0; b < 9; b++) begin
      if (b < int'(w_keep)) w_in_data[b*BYTE_W +: BYTE_W] = rd_data[b*BYTE_W +: BYTE_W];
    end
  end

  // An empty queue lets the arriving word through in the same cycle.
  assign w_bypass    = (r_q_cnt == 2'd0) && r_if_valid;
  assign wt_valid    = (r_q_cnt != 2'd0) || r_if_valid;
  assign w_head_data = w_bypass ? w_in_data : r_q_data[r_q_rd];
  assign w_head_tag  = w_bypass ? r_if_tag  : r_q_tag[r_q_rd];

  assign wt_data        = wt_valid ? w_head_data : '0;
  assign wt_mode        = wt_valid ? w_head_tag.mode : 3'd0;
  assign wt_last_seg    = wt_valid && w_head_tag.last_seg;
  assign wt_last_kernel = wt_valid && w_head_tag.last_kernel;

  assign w_pop  = wt_valid && wt_ready;
  assign w_push = r_if_valid && !(w_bypass && wt_ready);
  assign w_qpop = (r_q_cnt != 2'd0) && wt_ready;

  assign w_occ  = {1'b0, r_q_cnt} + {2'b00, r_if_valid};
  assign w_need = w_occ - {2'b00, w_pop};
  assign rd_en  = (r_state == S_ISSUE) && (w_need < 3'd2);

  assign rd_addr = r_addr;
  assign busy    = r_busy;
  assign done    = r_done;

  // NOTE: queue storage is left unreset; validity lives in r_q_cnt and the
  // outputs are gated by wt_valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_q_wr] <= w_in_data;
      r_q_tag[r_q_wr]  <= r_if_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_wr     <= 1'b0;
      r_q_rd     <= 1'b0;
      r_q_cnt    <= 2'd0;
      r_if_valid <= 1'b0;
      r_if_tag   <= '0;
    end else begin
      r_if_valid <= rd_en;
      if (rd_en) r_if_tag <= w_issue_tag;
      if (w_push) r_q_wr <= !r_q_wr;
      if (w_qpop) r_q_rd <= !r_q_rd;
      case ({w_push, w_qpop})
        2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mode5 <= 1'b0;
      r_knum  <= '0;
      r_kcnt  <= '0;
      r_seg   <= 2'd0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (kernel_num == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
              r_mode5 <= kernel_mode;
              r_knum  <= kernel_num;
              r_kcnt  <= '0;
              r_seg   <= 2'd0;
              r_addr  <= base_addr;
            end
          end
        end
        S_ISSUE: begin
          if (rd_en) begin
            r_addr <= (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
            if (w_issue_tag.last_seg) begin
              r_seg  <= 2'd0;
              r_kcnt <= r_kcnt + 1'b1;
            end else begin
              r_seg  <= r_seg + 2'd1;
            end
            if (w_issue_tag.last_kernel) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && wt_last_kernel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_seg_sched.sv
// Bench for wt_seg_sched: job table, directed corner sequences and random jobs,
// all scored against a segment list derived from the buffer contents.
module tb_wt_seg_sched;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int KCNT_W = 16;
  localparam int WORD_W = 72;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              kernel_mode = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [KCNT_W-1:0] kernel_num = '0;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data = '0;
  logic              wt_valid;
  logic              wt_ready = 1'b0;
  logic [WORD_W-1:0] wt_data;
  logic [2:0]        wt_mode;
  logic              wt_last_seg, wt_last_kernel;

  wt_seg_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .KCNT_W(KCNT_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_mode(kernel_mode),
    .base_addr(base_addr), .kernel_num(kernel_num), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wt_valid(wt_valid),
    .wt_ready(wt_ready), .wt_data(wt_data), .wt_mode(wt_mode),
    .wt_last_seg(wt_last_seg), .wt_last_kernel(wt_last_kernel)
  );

  always #5 clk = ~clk;

  // Weight buffer with one cycle of read latency.
  logic [WORD_W-1:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [2:0]        mode;
    logic              ls;
    logic              lk;
  } seg_t;

  typedef struct {
    logic km;
    int   base;
    int   kn;
    int   exp_segs;
    int   exp_done;
  } vec_t;

  seg_t exp_q[$];
  seg_t got_log[$];
  int   addr_log[$];
  int   total_chk = 0;
  int   bad_chk = 0;

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    total_chk++;
    if (act !== exp) begin
      bad_chk++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w, input int mode);
    int keep;
    logic [WORD_W-1:0] m;
    keep = (mode == 1 || mode == 2) ? 6 : (mode == 3) ? 4 : 9;
    m = '1;
    m = m >> (8 * (9 - keep));
    return w & m;
  endfunction

  // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 3..7.
  task automatic run_job(input logic km, input int base, input int kn, input int rmode,
                         input int extra_cyc, output int done_cyc);
    int   nseg, total, issued, accepted;
    bit   pop, prev_stall, exp_rd, exp_busy, exp_done;
    logic [WORD_W-1:0] prev_data;
    seg_t e;
    nseg = km ? 4 : 1;
    total = kn * nseg;
    exp_q.delete();
    got_log.delete();
    addr_log.delete();
    for (int k = 0; k < kn; k++) begin
      for (int s = 0; s < nseg; s++) begin
        e.data = mask_word(mem[(base + k * nseg + s) % DEPTH], km ? s : 4);
        e.mode = km ? 3'(s) : 3'd4;
        e.ls   = (s == nseg - 1);
        e.lk   = e.ls && (k == kn - 1);
        exp_q.push_back(e);
      end
    end
    issued = 0;
    accepted = 0;
    prev_stall = 0;
    prev_data = '0;
    done_cyc = -1;
    @(posedge clk);
    for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
      #1;
      start = (c == 0) || (c == extra_cyc);
      if (c == 0) begin
        kernel_mode = km;
        base_addr   = ADDR_W'(base);
        kernel_num  = KCNT_W'(kn);
      end else if (c == extra_cyc) begin
        kernel_mode = ~km;
        base_addr   = ADDR_W'(base + 37);
        kernel_num  = KCNT_W'(kn + 5);
      end
      case (rmode)
        0:       wt_ready = 1'b1;
        1:       wt_ready = ($urandom_range(0, 3) != 0);
        default: wt_ready = !(c >= 3 && c <= 7);
      endcase
      @(negedge clk);
      pop      = wt_valid && wt_ready;
      exp_rd   = (c >= 1) && (issued < total) && ((issued - accepted - int'(pop)) < 2);
      exp_busy = (kn != 0) && (c >= 1) && (accepted < total);
      exp_done = (kn == 0) ? (c == 1) : ((c >= 1) && (accepted == total));
      check("rd_en", WORD_W'(rd_en), WORD_W'(exp_rd));
      check("busy", WORD_W'(busy), WORD_W'(exp_busy));
      check("done", WORD_W'(done), WORD_W'(exp_done));
      if (rd_en) begin
        check("rd_addr", WORD_W'(rd_addr), WORD_W'((base + issued) % DEPTH));
        addr_log.push_back(int'(rd_addr));
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", WORD_W'(wt_valid), WORD_W'(1));
        check("stall_data", wt_data, prev_data);
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("extra_segment", WORD_W'(1), WORD_W'(0));
        end else begin
          e = exp_q.pop_front();
          check("seg_data", wt_data, e.data);
          check("seg_mode", WORD_W'(wt_mode), WORD_W'(e.mode));
          check("seg_last_seg", WORD_W'(wt_last_seg), WORD_W'(e.ls));
          check("seg_last_kernel", WORD_W'(wt_last_kernel), WORD_W'(e.lk));
          e.data = wt_data;
          e.mode = wt_mode;
          e.ls   = wt_last_seg;
          e.lk   = wt_last_kernel;
          got_log.push_back(e);
        end
        accepted++;
      end
      prev_stall = wt_valid && !wt_ready;
      prev_data  = wt_data;
      if (done) done_cyc = c;
      @(posedge clk);
    end
    #1 start = 1'b0;
    if (done_cyc < 0) check("job_timeout", WORD_W'(0), WORD_W'(1));
    check("all_delivered", WORD_W'(exp_q.size()), WORD_W'(0));
  endtask

  vec_t vecs[6];
  int   dc;
  int   wexp[4];
  logic [WORD_W-1:0] kword;
  logic [WORD_W-1:0] kexp[4];

  initial begin
    vecs[0] = '{km: 1'b0, base: 10,  kn: 2, exp_segs: 2,  exp_done: 4};
    vecs[1] = '{km: 1'b1, base: 0,   kn: 1, exp_segs: 4,  exp_done: 6};
    vecs[2] = '{km: 1'b1, base: 510, kn: 1, exp_segs: 4,  exp_done: 6};
    vecs[3] = '{km: 1'b0, base: 511, kn: 3, exp_segs: 3,  exp_done: 5};
    vecs[4] = '{km: 1'b1, base: 100, kn: 3, exp_segs: 12, exp_done: 14};
    vecs[5] = '{km: 1'b0, base: 0,   kn: 0, exp_segs: 0,  exp_done: 1};

    for (int i = 0; i < DEPTH; i++) mem[i] = WORD_W'({$urandom(), $urandom(), $urandom()});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", WORD_W'(busy), WORD_W'(0));
    check("rst_done", WORD_W'(done), WORD_W'(0));
    check("rst_rd_en", WORD_W'(rd_en), WORD_W'(0));
    check("rst_valid", WORD_W'(wt_valid), WORD_W'(0));
    check("rst_data", wt_data, WORD_W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of jobs with wt_ready held high.
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].km, vecs[i].base, vecs[i].kn, 0, -1, dc);
      check("tbl_done_cycle", WORD_W'(dc), WORD_W'(vecs[i].exp_done));
      check("tbl_seg_count", WORD_W'(got_log.size()), WORD_W'(vecs[i].exp_segs));
    end

    // 5x5 masking with a known word.
    kword = 72'h090807060504030201;
    for (int i = 200; i < 204; i++) mem[i] = kword;
    kexp[0] = 72'h090807060504030201;
    kexp[1] = 72'h000000060504030201;
    kexp[2] = 72'h000000060504030201;
    kexp[3] = 72'h000000000004030201;
    run_job(1'b1, 200, 1, 0, -1, dc);
    check("mask_count", WORD_W'(got_log.size()), WORD_W'(4));
    for (int i = 0; i < 4 && i < got_log.size(); i++) begin
      check("mask_data", got_log[i].data, kexp[i]);
      check("mask_mode", WORD_W'(got_log[i].mode), WORD_W'(i));
      check("mask_last", WORD_W'({got_log[i].ls, got_log[i].lk}), WORD_W'((i == 3) ? 3 : 0));
    end

    // Address wrap.
    wexp[0] = 510; wexp[1] = 511; wexp[2] = 0; wexp[3] = 1;
    run_job(1'b1, 510, 1, 0, -1, dc);
    check("wrap_count", WORD_W'(addr_log.size()), WORD_W'(4));
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("wrap_addr", WORD_W'(addr_log[i]), WORD_W'(wexp[i]));

    // Backpressure with a start pulse while busy.
    run_job(1'b1, 300, 2, 2, 5, dc);
    check("bp_seg_count", WORD_W'(got_log.size()), WORD_W'(8));
    check("bp_read_count", WORD_W'(addr_log.size()), WORD_W'(8));

    // Reset while draining.
    @(posedge clk);
    #1 start = 1'b1; kernel_mode = 1'b0; base_addr = 9'd40; kernel_num = 16'd1; wt_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", WORD_W'(wt_valid), WORD_W'(1));
    check("pre_rst_busy", WORD_W'(busy), WORD_W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", WORD_W'(busy), WORD_W'(0));
    check("mid_rst_rd_en", WORD_W'(rd_en), WORD_W'(0));
    check("mid_rst_addr", WORD_W'(rd_addr), WORD_W'(0));
    check("mid_rst_valid", WORD_W'(wt_valid), WORD_W'(0));
    check("mid_rst_data", wt_data, WORD_W'(0));
    check("mid_rst_flags", WORD_W'({wt_mode, wt_last_seg, wt_last_kernel}), WORD_W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1; wt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", WORD_W'(done), WORD_W'(0));
      check("post_rst_busy", WORD_W'(busy), WORD_W'(0));
    end
    run_job(1'b1, 7, 2, 0, 3, dc);
    check("post_rst_job_done", WORD_W'(dc), WORD_W'(10));

    // Random jobs under random backpressure.
    for (int i = 0; i < 10; i++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = WORD_W'({$urandom(), $urandom(), $urandom()});
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
              (i == 4) ? 0 : int'($urandom_range(1, 6)), 1,
              (i % 3 == 0) ? 4 : -1, dc);
    end

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule

// File: doc/wt_seg_sched.md
Name: wt_seg_sched

Overview:
- Weight-segment scheduler between the weight buffer (CONF_WT_BUF_DEPTH=512) and the PE matrix weight loaders.
- On `start`, walks a contiguous kernel region of the weight buffer.
- Emits one tagged segment per weight-buffer word:
  - 5×5 kernel: four segments, modes A,B,C,D (9+6+6+4 = 25 bytes).
  - 3×3 kernel: one segment, mode E (9 bytes).
- Handles the 1-cycle read latency with a 2-entry output queue, so full throughput holds under backpressure.

Parameters:
- DEPTH, 512, weight buffer depth in words.
- ADDR_W, 9, weight buffer address width (log2 DEPTH).
- KCNT_W, 16, kernel counter width.
- WORD_W, 72, weight word width (9 × BIT_WIDTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle launch pulse; ignored while busy.
- kernel_mode  in  1  0: 3×3 (E only), 1: 5×5 (A,B,C,D); sampled at start.
- base_addr  in  ADDR_W  first word address; sampled at start.
- kernel_num  in  KCNT_W  number of kernels; sampled at start.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  1-cycle pulse at job completion.
- rd_en  out  1  weight buffer read strobe.
- rd_addr  out  ADDR_W  weight buffer read address.
- rd_data  in  WORD_W  read data, valid exactly 1 cycle after rd_en.
- wt_valid  out  1  segment available.
- wt_ready  in  1  PE side accepts segment.
- wt_data  out  WORD_W  segment bytes; byte0 in [7:0].
- wt_mode  out  3  PE_weight_mode_t encoding: A=0, B=1, C=2, D=3, E=4.
- wt_last_seg  out  1  final segment of the current kernel.
- wt_last_kernel  out  1  final segment of the job.

Behaviour:
- **Reset:**
  - All outputs reset to 0; FSM goes to IDLE; queue and in-flight flag cleared.
  - Reset mid-job aborts with no done pulse.
- **FSM states:** IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE: on start with kernel_num≠0. Capture the config; busy=1 next cycle.
  - IDLE→IDLE: on start with kernel_num=0. done pulses the next cycle; busy stays 0; no reads.
  - ISSUE→DRAIN: after the read for the last segment of the last kernel is issued.
  - DRAIN→IDLE: on the handshake of the segment flagged wt_last_kernel. done=1 and busy=0 in the following cycle.
- **Issue rule:** in ISSUE, rd_en=1 iff (queue_count + inflight − pop) < 2, where pop = wt_valid & wt_ready this cycle.
- **Address sequencing:**
  - rd_addr starts at base_addr and increments by 1 per issued read.
  - Wraps from DEPTH−1 to 0.
- **Segment tagging (at issue time):**
  - Segment index s cycles 0..3 (5×5) or stays 0 (3×3).
  - Mode: s=0→A, 1→B, 2→C, 3→D; E for 3×3.
  - Tag, last_seg and last_kernel travel with the read into the queue.
- **Masking on queue write:**
  - B, C: bytes 8..6 forced to 0.
  - D: bytes 8..4 forced to 0.
  - A, E: all 9 bytes passed.
- **Output handshake:**
  - wt_valid = queue non-empty; the head drives wt_data, wt_mode and the last flags.
  - Data is held stable while wt_valid & !wt_ready.
  - Simultaneous queue write and pop are legal; the queue never overflows because of the issue rule.
- **Latency and throughput:**
  - start at cycle 0 → first rd_en at cycle 1 → first wt_valid at cycle 2.
  - With wt_ready held high: 1 segment/cycle, no bubbles.
- **Counters:**
  - Kernel counter runs to kernel_num−1.
  - The total segment count is never materialised: kernel_num·4 may exceed KCNT_W.
- **Busy handling:** start during busy is ignored; no config is recaptured.

Test Plan:
1. **3×3, two kernels, wt_ready=1.** kernel_mode=0, base=10, kernel_num=2.
   - rd_addr 10, 11 at cycles 1, 2.
   - Segments E, E at cycles 2, 3; last_seg=1 on both; last_kernel on the second.
   - done at cycle 4.
2. **5×5, one kernel, rd_data=0x090807060504030201 every read.**
   - Modes A, B, C, D in that order.
   - wt_data: A=0x090807060504030201, B=C=0x000000060504030201, D=0x000000000004030201.
   - last_seg and last_kernel on D only.
3. **Backpressure.** 5×5, kernel_num=2; wt_ready low cycles 3–7.
   - At most 2 reads outstanding (queue + in flight); rd_en stays low while full.
   - wt_data held stable while stalled.
   - All 8 segments delivered in order; none lost or duplicated.
4. **Wrap.** 5×5, base=510, kernel_num=1.
   - rd_addr sequence 510, 511, 0, 1.
5. **Zero kernels.** kernel_num=0 start.
   - No rd_en; busy stays 0; done pulses once at cycle 1.
6. **Reset mid-job, then start during busy.**
   - rst_n low in DRAIN: all outputs 0 immediately, no done.
   - A subsequent start runs normally.
   - A start issued while busy produces no extra reads.
